// File: rtl/logic_unit_pipe.sv
// Elastic STAGES-deep pipeline applying one of eight bitwise gate ops to WIDTH-bit operands.
// Optional feature macro: LOGIC_UNIT_REDUCE_EN adds red_out = {&res, |res, ^res} carried with each beat.
module logic_unit_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_out,
  output logic [2:0]       op_out,
  output logic             zero_out,
  output logic [15:0]      beats_out
`ifdef LOGIC_UNIT_REDUCE_EN
  ,
  output logic [2:0]       red_out
`endif
);

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("logic_unit_pipe: STAGES must be in 1..4");
    end
  endgenerate

  // Handshake: a beat moves across a boundary on a rising edge where the sender's valid
  // and the receiver's ready are both 1; valid never waits on ready, ready never looks at in_valid.

  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0][2:0]       op_q, op_d;
  logic [STAGES-1:0][WIDTH-1:0] res_q, res_d;
  logic [STAGES-1:0]            zero_q, zero_d;
`ifdef LOGIC_UNIT_REDUCE_EN
  logic [STAGES-1:0][2:0]       red_q, red_d;
`endif
  logic [15:0]                  beats_q, beats_d;

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] rdy;
  logic              downstream;
  logic [WIDTH-1:0]  res_calc;

  // Ready ripples backwards from the sink so empty stages (bubbles) always collapse.
  always_comb begin
    downstream = out_ready;
    adv        = '0;
    rdy        = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]     = vld_q[k] && downstream;
      rdy[k]     = !vld_q[k] || adv[k];
      downstream = rdy[k];
    end
  end

  always_comb begin
    res_calc = '0;
    case (op_in)
      3'd0:    res_calc = ~a_in;
      3'd1:    res_calc = a_in;
      3'd2:    res_calc = a_in & b_in;
      3'd3:    res_calc = a_in | b_in;
      3'd4:    res_calc = ~(a_in & b_in);
      3'd5:    res_calc = ~(a_in | b_in);
      3'd6:    res_calc = a_in ^ b_in;
      default: res_calc = ~(a_in ^ b_in);
    endcase
  end

  always_comb begin
    vld_d  = vld_q;
    op_d   = op_q;
    res_d  = res_q;
    zero_d = zero_q;
`ifdef LOGIC_UNIT_REDUCE_EN
    red_d  = red_q;
`endif
    for (int k = 0; k < STAGES; k++) begin
      if (adv[k]) vld_d[k] = 1'b0;
    end
    if (in_valid && rdy[0]) begin
      vld_d[0]  = 1'b1;
      op_d[0]   = op_in;
      res_d[0]  = res_calc;
      zero_d[0] = (res_calc == '0);
`ifdef LOGIC_UNIT_REDUCE_EN
      red_d[0]  = {&res_calc, |res_calc, ^res_calc};
`endif
    end
    // A stage reloads from its predecessor in the same cycle it hands its own beat on.
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k-1]) begin
        vld_d[k]  = 1'b1;
        op_d[k]   = op_q[k-1];
        res_d[k]  = res_q[k-1];
        zero_d[k] = zero_q[k-1];
`ifdef LOGIC_UNIT_REDUCE_EN
        red_d[k]  = red_q[k-1];
`endif
      end
    end
    beats_d = (vld_q[STAGES-1] && out_ready) ? beats_q + 16'd1 : beats_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= '0;
`ifdef LOGIC_UNIT_REDUCE_EN
      red_q   <= '0;
`endif
      beats_q <= '0;
    end else begin
      vld_q   <= vld_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
`ifdef LOGIC_UNIT_REDUCE_EN
      red_q   <= red_d;
`endif
      beats_q <= beats_d;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[STAGES-1];
  assign res_out   = res_q[STAGES-1];
  assign op_out    = op_q[STAGES-1];
  assign zero_out  = zero_q[STAGES-1];
  assign beats_out = beats_q;
`ifdef LOGIC_UNIT_REDUCE_EN
  assign red_out   = red_q[STAGES-1];
`endif

endmodule
